delay_scheduler: RTL and testbench
==================================

# delay_scheduler

Shares one programmable delay counter among `N_REQ` requesters. Each requester asks for a one-shot delay of its own length, and the block grants the counter round-robin. It runs the countdown and returns a single-cycle `done` pulse to the owner. It sits between the control FSMs that need timed waits and the shared timer resource, replacing per-client free-running generators.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `DELAY_W`, 16, width of each delay request in cycles

- `clk`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  `N_REQ`  level request, bit i = requester i
- `delay`  in  `N_REQ*DELAY_W`  requester i delay at `[i*DELAY_W +: DELAY_W]`, sampled only at grant
- `grant`  out  `N_REQ`  one-hot owner of the counter, all zero when free
- `busy`  out  1  counter owned (= |`grant`)
- `done`  out  `N_REQ`  one-cycle completion pulse to the owner
- `count`  out  `DELAY_W`  current remaining count, 0 when free

## Operation
- States: IDLE, COUNT, DONE. Reset state IDLE.
- **Round-robin pointer** `last`:
  - Resets to `N_REQ-1`, so requester 0 has first priority.
  - Search order is `last+1`, `last+2` … wrapping modulo `N_REQ`.
- **IDLE**: on an edge with any `req` bit high, pick the winner w.
  - Set `grant[w]`, load `count` = `delay[w]`, set `last` = w, go to COUNT.
  - A `delay` of 0 is loaded as 1.
- **COUNT**:
  - While `count` > 1, each edge decrements `count`.
  - On the edge where `count` == 1: go to DONE, set `done[w]`, clear `grant` and `count`.
- **DONE**, for one cycle: arbitrate exactly as in IDLE, with requester w masked.
  - If another request is pending, grant it at this edge and go to COUNT.
  - Otherwise go to IDLE.
  - `done` clears at this edge in either case.
- `req` changes during COUNT are ignored: no preemption, no abort. The owner dropping `req` does not cancel its countdown.
- Requests are not queued. A requester is served only if its `req` bit is high on an arbitration edge.
- At most one `grant` bit and at most one `done` bit are ever high. `grant` and `done` are never high together.
- All outputs are registered. No combinational path from `req` to any output.

## Timing
- **Reset** (`rst_n` low, asynchronous, any state including mid-COUNT):
  - `grant`=0, `done`=0, `busy`=0, `count`=0, state IDLE, `last`=`N_REQ-1`.
  - The in-flight job is dropped with no `done`.
  - First arbitration is on the first edge after `rst_n` deasserts.
- **Grant latency**: `req` high before edge E0 in IDLE gives `grant` high after E0, with `count`=D.
- **Countdown**: `count` = D−k after edge Ek. `done` is high after edge ED, i.e. exactly D cycles after `grant` rose, for D≥1.
- **Back-to-back**: the next owner's `grant` rises at E(D+1), so there is a one-cycle gap (the DONE cycle) between owners.
- **Sole requester**: if only requester w is pending in DONE, it is re-granted at E(D+2), via IDLE.
- **Max D**: `2^DELAY_W − 1`. No wrap, because the counter never decrements below 1.

## Test plan
- **Reset values**: hold `rst_n`=0 with random `req` → all outputs 0. Release, `req`=0001, `delay[0]`=5 → `grant`=0001 after the next edge, `done[0]` pulses 5 cycles later for exactly 1 cycle.
- **Zero delay**: `req`=0010, `delay[1]`=0 → `grant` high 1 cycle, then `done[1]` high 1 cycle, then `grant`=0.
- **Round-robin**: `req`=1111 held, all delays 3 → grant order 0,1,2,3,0. Each `done` is 3 cycles after its grant, with a 1-cycle gap between grants.
- **DONE masking**: only `req[2]` held, `delay[2]`=2 → `grant[2]` high 2 cycles, `done` 1 cycle, IDLE 0 cycles of grant, then re-granted on the following edge (period 4).
- **No preemption**: grant requester 0 with D=10, drop `req[0]` and raise `req[3]` at cycle 4 → `done[0]` still at cycle 10, `grant[3]` at cycle 11.
- **Mid-count reset**: assert `rst_n`=0 asynchronously at `count`=7 → `grant`/`count` clear immediately, no `done`. After release, `req`=1000 alone → granted first edge.

Source files
------------

// File: rtl/delay_scheduler_if.sv
// delay_scheduler request/grant bundle.
// master = requester side, slave = scheduler side.
interface delay_scheduler_if #(
  parameter int N_REQ   = 4,
  parameter int DELAY_W = 16
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*DELAY_W-1:0] delay;
  logic [N_REQ-1:0]         grant;
  logic                     busy;
  logic [N_REQ-1:0]         done;
  logic [DELAY_W-1:0]       count;

  modport master (
    output req, delay,
    input  grant, busy, done, count
  );

  modport slave (
    input  req, delay,
    output grant, busy, done, count
  );
endinterface

// File: rtl/delay_scheduler.sv
// Shared one-shot delay counter, granted round-robin
// to N_REQ requesters; done pulses to the owner.
module delay_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DELAY_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  delay_scheduler_if.slave   bus
);
  localparam int LW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t             state;
  logic [LW-1:0]      last;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               busy_q;
  logic [DELAY_W-1:0] count_q;

  logic               found;
  logic [LW-1:0]      win;
  logic [DELAY_W-1:0] win_delay;
  logic [DELAY_W-1:0] load;

  // In DONE, last still holds the finishing owner, so mask it
  always_comb begin
    logic [LW-1:0] cand;
    cand  = '0;
    found = 1'b0;
    win   = last;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = LW'((int'(last) + k) % N_REQ);
      if (!found && bus.req[cand] &&
          !(state == DONE && cand == last)) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_delay =
    bus.delay[int'(win)*DELAY_W +: DELAY_W];
  assign load = (win_delay == '0) ?
    DELAY_W'(1) : win_delay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= LW'(N_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= '0;
          if (found) begin
            state   <= COUNT;
            last    <= win;
            grant_q <= N_REQ'(1) << win;
            busy_q  <= 1'b1;
            count_q <= load;
          end else begin
            state <= IDLE;
          end
        end
        COUNT: begin
          if (count_q > DELAY_W'(1)) begin
            count_q <= count_q - DELAY_W'(1);
          end else begin
            state   <= DONE;
            done_q  <= N_REQ'(1) << last;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: vector table, hand
// sequences and a random run against a timeline model.
module tb_delay_scheduler;
  localparam int N = 4;
  localparam int W = 16;

  logic clk;
  logic rst_n;

  delay_scheduler_if #(.N_REQ(N), .DELAY_W(W)) bus ();

  delay_scheduler #(.N_REQ(N), .DELAY_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] dly;
    logic [N-1:0]  g;
    logic [N-1:0]  d;
    logic [W-1:0]  c;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nbad = 0;

  // timeline model state
  int m_own, m_tg, m_len, m_last;
  int m_arb, m_mask, ecnt;
  logic [N-1:0] e_g, e_d;
  logic [W-1:0] e_c;

  function automatic logic [N*W-1:0] dl(int i, int v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic void add(logic rst, logic [N-1:0] r,
      logic [N*W-1:0] dv, logic [N-1:0] g,
      logic [N-1:0] d, int c);
    vec_t v;
    v.rst = rst; v.req = r; v.dly = dv;
    v.g = g; v.d = d; v.c = W'(c);
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic [N-1:0] g,
                         logic [N-1:0] d, int c);
    chk({nm, ".grant"}, 32'(bus.grant), 32'(g));
    chk({nm, ".done"},  32'(bus.done),  32'(d));
    chk({nm, ".count"}, 32'(bus.count), 32'(c));
    chk({nm, ".busy"},  32'(bus.busy),  32'(|g));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = N'($urandom);
    bus.delay = {N*W{1'b0}};
    @(posedge clk);
    #1;
    chk_out("reset", '0, '0, 0);
    bus.req = '0;
    rst_n = 1'b1;
  endtask

  function automatic void model_reset();
    m_own = -1; m_tg = 0; m_len = 0;
    m_last = N - 1; m_arb = 0; m_mask = -1;
    ecnt = 0;
  endfunction

  function automatic void model_step(logic [N-1:0] r,
                                     logic [N*W-1:0] dv);
    int w, idx, dd;
    e_d = '0;
    if (m_own >= 0 && ecnt == m_tg + m_len) begin
      e_d = N'(1) << m_own;
      m_mask = m_own;
      m_arb = ecnt + 1;
      m_own = -1;
    end else if (m_own < 0 && ecnt >= m_arb) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (w < 0 && r[idx] &&
            !(ecnt == m_arb && idx == m_mask))
          w = idx;
      end
      if (w >= 0) begin
        dd = int'(dv[w*W +: W]);
        m_own = w; m_tg = ecnt;
        m_len = (dd == 0) ? 1 : dd;
        m_last = w;
      end
    end
    e_g = (m_own >= 0) ? N'(1) << m_own : '0;
    e_c = (m_own >= 0) ? W'(m_len - (ecnt - m_tg)) : '0;
    ecnt++;
  endfunction

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.delay = '0;

    // reset release then D=5 on requester 0
    add(1, 4'b0001, dl(0, 5), 4'b0001, 0, 5);
    for (int k = 4; k >= 1; k--)
      add(0, 4'b0001, dl(0, 5), 4'b0001, 0, k);
    add(0, 4'b0001, dl(0, 5), 0, 4'b0001, 0);
    add(0, 4'b0000, dl(0, 5), 0, 0, 0);
    // zero delay loads as one
    add(1, 4'b0010, dl(1, 0), 4'b0010, 0, 1);
    add(0, 4'b0000, dl(1, 0), 0, 4'b0010, 0);
    add(0, 4'b0000, dl(1, 0), 0, 0, 0);
    // round robin, all delays 3
    for (int j = 0; j < 5; j++) begin
      for (int k = 3; k >= 1; k--)
        add(j == 0 && k == 3, 4'b1111, {4{16'd3}},
            N'(1) << (j % N), 0, k);
      add(0, 4'b1111, {4{16'd3}},
          0, N'(1) << (j % N), 0);
    end
    // sole requester, period D+2
    for (int j = 0; j < 2; j++) begin
      add(j == 0, 4'b0100, dl(2, 2), 4'b0100, 0, 2);
      add(0, 4'b0100, dl(2, 2), 4'b0100, 0, 1);
      add(0, 4'b0100, dl(2, 2), 0, 4'b0100, 0);
      if (j == 0)
        add(0, 4'b0100, dl(2, 2), 0, 0, 0);
    end

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      bus.req = tbl[i].req;
      bus.delay = tbl[i].dly;
      @(posedge clk);
      #1;
      chk_out($sformatf("tbl%0d", i),
              tbl[i].g, tbl[i].d, int'(tbl[i].c));
    end

    // no preemption: owner drops req, requester 3 waits
    do_reset();
    bus.req = 4'b0001;
    bus.delay = dl(0, 10) | dl(3, 4);
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (e <= 9)
        chk_out("nopre", 4'b0001, 0, 10 - e);
      else if (e == 10)
        chk_out("nopre", 0, 4'b0001, 0);
      else
        chk_out("nopre", 4'b1000, 0, 4);
      if (e == 3) bus.req = 4'b1000;
    end

    // asynchronous reset mid-countdown
    do_reset();
    bus.req = 4'b0001;
    bus.delay = dl(0, 20);
    repeat (14) @(posedge clk);
    #1;
    chk("midrst.count7", 32'(bus.count), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midrst.async", 0, 0, 0);
    @(posedge clk);
    #1;
    chk_out("midrst.held", 0, 0, 0);
    bus.req = 4'b1000;
    bus.delay = dl(3, 5);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("midrst.first", 4'b1000, 0, 5);

    // random traffic against the timeline model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.req = ($urandom_range(0, 3) == 0) ?
                '0 : N'($urandom);
      for (int i = 0; i < N; i++)
        bus.delay[i*W +: W] = W'($urandom_range(0, 6));
      @(posedge clk);
      model_step(bus.req, bus.delay);
      #1;
      chk_out("rand", e_g, e_d, int'(e_c));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end
endmodule
